// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the registered ALU.
// There is no handshake: the master presents operands and an opcode every
// cycle, and the registered result and flags appear one rising edge later.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_ovf;

    // Execute stage: drives operands, reads registered result/flags.
    modport master (
        output alu_a,
        output alu_b,
        output alu_op,
        input  alu_out,
        input  alu_zero,
        input  alu_carry,
        input  alu_ovf
    );

    // ALU: reads operands, drives registered result/flags.
    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_op,
        output alu_out,
        output alu_zero,
        output alu_carry,
        output alu_ovf
    );
endinterface

// File: rtl/alu.sv
// Registered 32-bit ALU: 16 operations selected by a 5-bit opcode, result and
// carry/overflow/zero flags captured on the rising edge. Opcodes 16..31 are
// reserved and produce a zero result with only the zero flag set.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_NOTA  = 5'd11;
    localparam logic [4:0] OP_PASSA = 5'd12;
    localparam logic [4:0] OP_PASSB = 5'd13;
    localparam logic [4:0] OP_LUI   = 5'd14;
    localparam logic [4:0] OP_ROTL  = 5'd15;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [4:0]       w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;

    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;

    // Shared adder/subtractor; the extra top bit is the carry or the borrow.
    assign w_sum   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign w_diff  = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
    assign w_shamt = bus.alu_b[4:0];
    assign w_lt_s  = $signed(bus.alu_a) < $signed(bus.alu_b);
    assign w_lt_u  = bus.alu_a < bus.alu_b;

    // Operation select: result plus carry/overflow for the arithmetic ops.
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != bus.alu_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                w_ovf    = (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != bus.alu_a[WIDTH-1]);
            end
            OP_AND:   w_result = bus.alu_a & bus.alu_b;
            OP_OR:    w_result = bus.alu_a | bus.alu_b;
            OP_XOR:   w_result = bus.alu_a ^ bus.alu_b;
            OP_NOR:   w_result = ~(bus.alu_a | bus.alu_b);
            OP_SLT:   w_result = {{(WIDTH-1){1'b0}}, w_lt_s};
            OP_SLTU:  w_result = {{(WIDTH-1){1'b0}}, w_lt_u};
            OP_SLL:   w_result = bus.alu_a << w_shamt;
            OP_SRL:   w_result = bus.alu_a >> w_shamt;
            OP_SRA:   w_result = $unsigned($signed(bus.alu_a) >>> w_shamt);
            OP_NOTA:  w_result = ~bus.alu_a;
            OP_PASSA: w_result = bus.alu_a;
            OP_PASSB: w_result = bus.alu_b;
            OP_LUI:   w_result = {bus.alu_b[15:0], {(WIDTH-16){1'b0}}};
            // A shift by WIDTH yields zero, so amount 0 returns A unchanged.
            OP_ROTL:  w_result = (bus.alu_a << w_shamt) |
                                 (bus.alu_a >> (WIDTH - int'(w_shamt)));
            default: begin
                w_result = '0;
                w_carry  = 1'b0;
                w_ovf    = 1'b0;
            end
        endcase
    end

    // Result/flag register; reset wins over any op presented that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_out   <= w_result;
            r_zero  <= (w_result == '0);
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
        end
    end

    assign bus.alu_out   = r_out;
    assign bus.alu_zero  = r_zero;
    assign bus.alu_carry = r_carry;
    assign bus.alu_ovf   = r_ovf;
endmodule

// File: tb/tb_alu.sv
// Bench for the registered ALU: reset, table of directed vectors, multi-cycle
// corner sequences, then randomized ops against an arithmetic reference model.
module tb_alu;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [31:0] out;
        logic        zero;
        logic        carry;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] op, input logic [31:0] out,
                                input logic carry, input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.out = out;
        v.zero = (out == 32'h0); v.carry = carry; v.ovf = ovf;
        return v;
    endfunction

    // Driver tasks.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        bus.alu_a  = a;
        bus.alu_b  = b;
        bus.alu_op = op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic check_all(input string name, input logic [31:0] out, input logic zero,
                             input logic carry, input logic ovf);
        check({name, ".out"},   bus.alu_out,         out);
        check({name, ".zero"},  {31'b0, bus.alu_zero},  {31'b0, zero});
        check({name, ".carry"}, {31'b0, bus.alu_carry}, {31'b0, carry});
        check({name, ".ovf"},   {31'b0, bus.alu_ovf},   {31'b0, ovf});
    endtask

    // Reference model: plain integer arithmetic on the opcode rules.
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                             output logic [31:0] out, output logic zero,
                             output logic carry, output logic ovf);
        longint ua, ub, sa, sb, r, p, two32;
        int sh;
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        two32 = 64'd4294967296;
        sh = int'(b % 32);
        p = 1;
        repeat (sh) p = p * 2;
        carry = 1'b0;
        ovf   = 1'b0;
        r     = 0;
        case (int'(op))
            0: begin
                r = sa + sb;
                ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                carry = (ua + ub) >= two32;
            end
            1: begin
                r = sa - sb;
                ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                carry = ua < ub;
            end
            2: r = {32'h0, a & b};
            3: r = {32'h0, a | b};
            4: r = {32'h0, a ^ b};
            5: r = {32'h0, ~(a | b)};
            6: r = (sa < sb) ? 1 : 0;
            7: r = (ua < ub) ? 1 : 0;
            8: r = (ua * p) % two32;
            9: r = ua / p;
            10: r = (sa >= 0) ? sa / p : -(((-sa) - 1) / p) - 1;
            11: r = {32'h0, ~a};
            12: r = ua;
            13: r = ub;
            14: r = (ub % 65536) * 65536;
            15: r = ((ua * p) % two32) + (ua / (two32 / p));
            default: r = 0;
        endcase
        out  = r[31:0];
        zero = (out == 32'h0);
    endtask

    logic [31:0] m_out;
    logic        m_zero, m_carry, m_ovf;
    logic [31:0] corners[6];

    initial begin
        corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000; corners[3] = 32'h7FFF_FFFF;
        corners[4] = 32'h0000_0001; corners[5] = 32'h0000_001F;

        // Directed vectors, applied one per cycle.
        vecs.push_back(mk(32'd300, 32'd400, 5'd0, 32'd700,       1'b0, 1'b0));
        vecs.push_back(mk(32'd300, 32'd400, 5'd1, 32'hFFFFFF9C,  1'b1, 1'b0));
        vecs.push_back(mk(32'd300, 32'd400, 5'd2, 32'd256,       1'b0, 1'b0));
        vecs.push_back(mk(32'd300, 32'd400, 5'd3, 32'd444,       1'b0, 1'b0));
        vecs.push_back(mk(32'd300, 32'd400, 5'd4, 32'd188,       1'b0, 1'b0));
        vecs.push_back(mk(32'd300, 32'd400, 5'd5, 32'hFFFFFE43,  1'b0, 1'b0));
        vecs.push_back(mk(32'd300, 32'd400, 5'd6, 32'd1,         1'b0, 1'b0));
        vecs.push_back(mk(32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b0, 1'b1));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd1, 5'd0, 32'h00000000, 1'b1, 1'b0));
        vecs.push_back(mk(32'h80000000, 32'd1, 5'd1, 32'h7FFFFFFF, 1'b0, 1'b1));
        vecs.push_back(mk(32'd5, 32'd5, 5'd1, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h80000001, 32'd4, 5'd8,  32'h00000010, 1'b0, 1'b0));
        vecs.push_back(mk(32'h80000001, 32'd4, 5'd9,  32'h08000000, 1'b0, 1'b0));
        vecs.push_back(mk(32'h80000001, 32'd4, 5'd10, 32'hF8000000, 1'b0, 1'b0));
        vecs.push_back(mk(32'h80000001, 32'd1, 5'd15, 32'h00000003, 1'b0, 1'b0));
        vecs.push_back(mk(32'h80000001, 32'h20, 5'd8, 32'h80000001, 1'b0, 1'b0));
        vecs.push_back(mk(32'h80000000, 32'd31, 5'd10, 32'hFFFFFFFF, 1'b0, 1'b0));
        vecs.push_back(mk(32'h00000001, 32'hFFFFFFFF, 5'd8, 32'h80000000, 1'b0, 1'b0));
        vecs.push_back(mk(32'h80000001, 32'hFFFFFFE0, 5'd10, 32'h80000001, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd1, 5'd6, 32'd1, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd1, 5'd7, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h80000000, 32'd0, 5'd6, 32'd1, 1'b0, 1'b0));
        vecs.push_back(mk(32'h80000000, 32'd0, 5'd7, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h0000FFFF, 32'h1234, 5'd14, 32'h12340000, 1'b0, 1'b0));
        vecs.push_back(mk(32'h0, 32'hDEADBEEF, 5'd13, 32'hDEADBEEF, 1'b0, 1'b0));
        vecs.push_back(mk(32'hCAFEF00D, 32'h0, 5'd12, 32'hCAFEF00D, 1'b0, 1'b0));
        vecs.push_back(mk(32'h0, 32'h5, 5'd11, 32'hFFFFFFFF, 1'b0, 1'b0));
        vecs.push_back(mk(32'd5, 32'd5, 5'd20, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'd1, 5'd16, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h7FFFFFFF, 32'd1, 5'd31, 32'd0, 1'b0, 1'b0));

        // Reset held for two edges with an ADD presented.
        rst_n = 1'b0;
        drive(32'd300, 32'd400, 5'd0);
        tick();
        check_all("reset0", 32'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("reset1", 32'd0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_all("first_after_reset", 32'd700, 1'b0, 1'b0, 1'b0);

        // Table-driven vectors, back to back.
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].zero,
                      vecs[i].carry, vecs[i].ovf);
        end

        // Inputs changing between edges must not disturb the registered result.
        drive(32'd1, 32'd2, 5'd0);
        tick();
        check_all("hold_pre", 32'd3, 1'b0, 1'b0, 1'b0);
        drive(32'd100, 32'd100, 5'd4);
        #3;
        check_all("hold_mid", 32'd3, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("hold_post", 32'd0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream during back-to-back ADDs.
        drive(32'd10, 32'd20, 5'd0);
        tick();
        check_all("midrst_pre", 32'd30, 1'b0, 1'b0, 1'b0);
        drive(32'hFFFFFFFF, 32'd2, 5'd0);
        rst_n = 1'b0;
        tick();
        check_all("midrst_on", 32'd0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_all("midrst_off", 32'd1, 1'b0, 1'b1, 1'b0);

        // Randomized ops against the reference model, with corner operands mixed in.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rb;
            logic [4:0]  rop;
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rop = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31))
                                              : 5'($urandom_range(0, 15));
            ref_model(ra, rb, rop, m_out, m_zero, m_carry, m_ovf);
            drive(ra, rb, rop);
            tick();
            check_all($sformatf("rnd%0d_op%0d", i, rop), m_out, m_zero, m_carry, m_ovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
